// File: rtl/pe_mem_responder.sv
// pe_mem_responder: single-outstanding scratchpad answering the PE memory port.
// Fixed-latency 256-bit line reads/writes with an error response for bad addresses.
module pe_mem_responder #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int ACCESS_LAT = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  output logic                  mem_ack_o,
  output logic [LINE_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  access_cnt_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(ACCESS_LAT - 1);

  logic [1:0]            state;
  logic [3:0]            lat_cnt;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [LINE_WIDTH-1:0] cap_wdata;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  access_cnt;
  logic [LINE_WIDTH-1:0] mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] line;
  logic                  cap_err;
  logic                  ack_entry;

  assign line      = cap_addr[DEPTH_LOG2+4:5];
  assign cap_err   = (cap_addr[4:0] != 5'd0) ||
                     (cap_addr[ADDR_WIDTH-1:DEPTH_LOG2+5] != '0);
  assign ack_entry = (state == BUSY) && (lat_cnt == 4'd0);

  // Every latency, including 1, passes through BUSY so ACK is entered exactly
  // ACCESS_LAT edges after the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      access_cnt <= '0;
    end else begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_i) begin
            cap_we    <= mem_we_i;
            cap_addr  <= addr_i;
            cap_wdata <= wdata_i;
            lat_cnt   <= LAT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (lat_cnt == 4'd0) begin
            state <= ACK;
            err_q <= cap_err;
            if (!cap_err && !cap_we) begin
              rdata_q <= mem[line];
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ACK: begin
          access_cnt <= access_cnt + CNT_WIDTH'(1);
          state      <= DRAIN;
        end
        DRAIN: begin
          if (!mem_req_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A write commits only on an un-reset ACK-entry edge, so aborted writes leave the line intact.
  always_ff @(posedge clk) begin
    if (!rst && ack_entry && cap_we && !cap_err) begin
      mem[line] <= cap_wdata;
    end
  end

  assign mem_ack_o    = (state == ACK) && !rst;
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;
  assign busy_o       = (state != IDLE);
  assign access_cnt_o = access_cnt;

endmodule

// File: tb/tb_pe_mem_responder.sv
// tb_pe_mem_responder: randomized self-checking bench with a line-array reference model.
// Instance A uses default parameters; instance B uses ACCESS_LAT=1 and a 4-bit counter.
module tb_pe_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic         sel = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;

  logic         ack_a, err_a, busy_a, ack_b, err_b, busy_b;
  logic [255:0] rdata_a, rdata_b;
  logic [15:0]  cnt_a;
  logic [3:0]   cnt_b;

  logic         ack, err, busy;
  logic [255:0] rdata;
  logic [15:0]  cnt;

  assign ack   = sel ? ack_b : ack_a;
  assign err   = sel ? err_b : err_a;
  assign busy  = sel ? busy_b : busy_a;
  assign rdata = sel ? rdata_b : rdata_a;
  assign cnt   = sel ? {12'd0, cnt_b} : cnt_a;

  pe_mem_responder u_dut_a (
    .clk(clk), .rst(rst), .mem_req_i(req & ~sel), .mem_we_i(we), .addr_i(addr),
    .wdata_i(wdata), .mem_ack_o(ack_a), .rdata_o(rdata_a), .err_o(err_a),
    .busy_o(busy_a), .access_cnt_o(cnt_a)
  );

  pe_mem_responder #(.ACCESS_LAT(1), .CNT_WIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .mem_req_i(req & sel), .mem_we_i(we), .addr_i(addr),
    .wdata_i(wdata), .mem_ack_o(ack_b), .rdata_o(rdata_b), .err_o(err_b),
    .busy_o(busy_b), .access_cnt_o(cnt_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0] model_mem [2][256];
  bit           known [2][256];
  int           model_cnt [2];

  function automatic int lat_of(input int inst);
    return (inst == 1) ? 1 : 2;
  endfunction

  function automatic int cnt_mod(input int inst);
    return (inst == 1) ? 16 : 65536;
  endfunction

  // Reference: a line is 32 bytes, the store holds 256 lines, anything else is an error.
  function automatic void model_expect(input int inst, input logic w, input logic [31:0] a,
                                       input logic [255:0] d, output logic [255:0] e_rd,
                                       output logic e_err);
    int ln;
    e_err = ((a % 32) != 0) || (a >= 32'd8192);
    e_rd  = '0;
    if (!e_err) begin
      ln = int'(a / 32);
      if (w) begin
        model_mem[inst][ln] = d;
        known[inst][ln]     = 1'b1;
      end else begin
        e_rd = model_mem[inst][ln];
      end
    end
    model_cnt[inst] = (model_cnt[inst] + 1) % cnt_mod(inst);
  endfunction

  // Drives one access; scrambles the inputs right after capture; releases req after hold cycles.
  task automatic run_access(input int inst, input logic w, input logic [31:0] a,
                            input logic [255:0] d, input int hold, output int ack_c,
                            output int acks, output int ack_abs, output logic [255:0] rd,
                            output logic er, output logic busy_ok);
    sel = (inst == 1); we = w; addr = a; wdata = d; req = 1'b1;
    ack_c = -1; acks = 0; ack_abs = -1; rd = '0; er = 1'b0; busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        addr = $urandom; wdata = {8{$urandom}}; we = ~w;
      end
      if (!busy) busy_ok = 1'b0;
      if (ack) begin
        acks++;
        if (ack_c < 0) begin
          ack_c = c; ack_abs = cyc; rd = rdata; er = err;
        end
      end
      if (ack_c > 0 && c >= ack_c + hold) break;
    end
    req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack) acks++;
      if (!busy) break;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack_a !== 1'b0 || ack_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b%b expected 00", ack_a, ack_b); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b%b expected 00", busy_a, busy_b); end
    checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b%b expected 00", err_a, err_b); end
    checks++; if (rdata_a !== '0 || rdata_b !== '0) begin errors++; $display("[TB] FAIL reset_rdata: got %h / %h expected 0", rdata_a, rdata_b); end
    checks++; if (cnt_a !== 16'd0 || cnt_b !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d / %0d expected 0", cnt_a, cnt_b); end
    rst = 1'b0;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
  endtask

  task automatic test_read_after_write;
    logic [255:0] e_rd, rd; logic e_err, er, bo; int ac, an, aa;
    $display("[TB] test_read_after_write");
    model_expect(0, 1'b1, 32'h40, {32{8'hA5}}, e_rd, e_err);
    run_access(0, 1'b1, 32'h40, {32{8'hA5}}, 0, ac, an, aa, rd, er, bo);
    checks++; if (ac !== 3) begin errors++; $display("[TB] FAIL t1_write_latency: got %0d expected 3", ac); end
    checks++; if (er !== 1'b0 || rd !== '0) begin errors++; $display("[TB] FAIL t1_write_resp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    model_expect(0, 1'b0, 32'h40, '0, e_rd, e_err);
    run_access(0, 1'b0, 32'h40, '0, 0, ac, an, aa, rd, er, bo);
    checks++; if (ac !== 3) begin errors++; $display("[TB] FAIL t1_read_latency: got %0d expected 3", ac); end
    checks++; if (rd !== {32{8'hA5}} || er !== 1'b0) begin errors++; $display("[TB] FAIL t1_read_data: got err=%b rdata=%h expected err=0 rdata=%h", er, rd, {32{8'hA5}}); end
    checks++; if (cnt !== 16'(model_cnt[0])) begin errors++; $display("[TB] FAIL t1_count: got %0d expected %0d", cnt, model_cnt[0]); end
  endtask

  task automatic test_errors;
    logic [255:0] e_rd, rd, d0; logic e_err, er, bo; int ac, an, aa;
    $display("[TB] test_errors");
    d0 = {8{$urandom}};
    model_expect(0, 1'b1, 32'h0, d0, e_rd, e_err);
    run_access(0, 1'b1, 32'h0, d0, 0, ac, an, aa, rd, er, bo);
    model_expect(0, 1'b0, 32'h44, '0, e_rd, e_err);
    run_access(0, 1'b0, 32'h44, '0, 0, ac, an, aa, rd, er, bo);
    checks++; if (ac !== 3 || er !== 1'b1 || rd !== '0) begin errors++; $display("[TB] FAIL t2_misaligned: got lat=%0d err=%b rdata=%h expected lat=3 err=1 rdata=0", ac, er, rd); end
    model_expect(0, 1'b1, 32'h2000, '1, e_rd, e_err);
    run_access(0, 1'b1, 32'h2000, '1, 0, ac, an, aa, rd, er, bo);
    checks++; if (er !== 1'b1 || rd !== '0) begin errors++; $display("[TB] FAIL t2_out_of_range: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    model_expect(0, 1'b0, 32'h0, '0, e_rd, e_err);
    run_access(0, 1'b0, 32'h0, '0, 0, ac, an, aa, rd, er, bo);
    checks++; if (rd !== e_rd || er !== 1'b0) begin errors++; $display("[TB] FAIL t2_line0_intact: got %h expected %h", rd, e_rd); end
    checks++; if (cnt !== 16'(model_cnt[0])) begin errors++; $display("[TB] FAIL t2_count: got %0d expected %0d", cnt, model_cnt[0]); end
  endtask

  task automatic test_held_req;
    logic [255:0] e_rd, rd; logic e_err, er, bo; int ac, an, aa;
    $display("[TB] test_held_req");
    model_expect(0, 1'b0, 32'h40, '0, e_rd, e_err);
    run_access(0, 1'b0, 32'h40, '0, 10, ac, an, aa, rd, er, bo);
    checks++; if (an !== 1) begin errors++; $display("[TB] FAIL t3_ack_count: got %0d expected 1", an); end
    checks++; if (bo !== 1'b1) begin errors++; $display("[TB] FAIL t3_busy_held: got %b expected 1", bo); end
    checks++; if (rd !== e_rd) begin errors++; $display("[TB] FAIL t3_data: got %h expected %h", rd, e_rd); end
    model_expect(0, 1'b0, 32'h0, '0, e_rd, e_err);
    run_access(0, 1'b0, 32'h0, '0, 0, ac, an, aa, rd, er, bo);
    checks++; if (ac !== 3 || an !== 1 || rd !== e_rd) begin errors++; $display("[TB] FAIL t3_next_access: got lat=%0d acks=%0d rdata=%h expected lat=3 acks=1 rdata=%h", ac, an, rd, e_rd); end
  endtask

  task automatic test_lat1;
    logic [255:0] e_rd, rd, d; logic e_err, er, bo; int ac, an, aa;
    $display("[TB] test_lat1");
    d = {8{$urandom}};
    model_expect(1, 1'b1, 32'h1E0, d, e_rd, e_err);
    run_access(1, 1'b1, 32'h1E0, d, 0, ac, an, aa, rd, er, bo);
    checks++; if (ac !== 2 || er !== 1'b0) begin errors++; $display("[TB] FAIL t6_write_latency: got lat=%0d err=%b expected lat=2 err=0", ac, er); end
    model_expect(1, 1'b0, 32'h1E0, '0, e_rd, e_err);
    run_access(1, 1'b0, 32'h1E0, '0, 0, ac, an, aa, rd, er, bo);
    checks++; if (ac !== 2 || rd !== d) begin errors++; $display("[TB] FAIL t6_read: got lat=%0d rdata=%h expected lat=2 rdata=%h", ac, rd, d); end
  endtask

  task automatic test_back_to_back;
    logic [255:0] e_rd, rd; logic e_err, er, bo; int ac, an, aa1, aa2;
    $display("[TB] test_back_to_back");
    for (int inst = 0; inst < 2; inst++) begin
      model_expect(inst, 1'b1, 32'h60, '1, e_rd, e_err);
      run_access(inst, 1'b1, 32'h60, '1, 0, ac, an, aa1, rd, er, bo);
      model_expect(inst, 1'b0, 32'h60, '0, e_rd, e_err);
      run_access(inst, 1'b0, 32'h60, '0, 0, ac, an, aa2, rd, er, bo);
      checks++; if (aa2 - aa1 !== lat_of(inst) + 3) begin errors++; $display("[TB] FAIL b2b_spacing_%0d: got %0d expected %0d", inst, aa2 - aa1, lat_of(inst) + 3); end
      checks++; if (rd !== e_rd) begin errors++; $display("[TB] FAIL b2b_data_%0d: got %h expected %h", inst, rd, e_rd); end
    end
  endtask

  task automatic test_random;
    logic [255:0] e_rd, rd, d; logic e_err, er, bo, w; logic [31:0] a; int ac, an, aa, inst, r, ln;
    $display("[TB] test_random");
    for (int i = 0; i < 30; i++) begin
      inst = $urandom_range(0, 1);
      w = $urandom_range(0, 1) == 1;
      d = {8{$urandom}};
      r = $urandom_range(0, 9);
      ln = $urandom_range(0, 15);
      if (r < 2) a = 32'(ln * 32 + $urandom_range(1, 31));
      else if (r == 2) a = 32'h2000 + 32'($urandom_range(0, 1000) * 32);
      else a = 32'(ln * 32);
      if (r >= 3 && !w && !known[inst][ln]) w = 1'b1;
      model_expect(inst, w, a, d, e_rd, e_err);
      run_access(inst, w, a, d, $urandom_range(0, 3), ac, an, aa, rd, er, bo);
      checks++; if (ac !== lat_of(inst) + 1 || an !== 1) begin errors++; $display("[TB] FAIL rand_timing: got lat=%0d acks=%0d expected lat=%0d acks=1", ac, an, lat_of(inst) + 1); end
      checks++; if (er !== e_err || rd !== e_rd) begin errors++; $display("[TB] FAIL rand_resp addr=%h we=%b: got err=%b rdata=%h expected err=%b rdata=%h", a, w, er, rd, e_err, e_rd); end
      checks++; if (cnt !== 16'(model_cnt[inst])) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", cnt, model_cnt[inst]); end
    end
  endtask

  task automatic test_reset_mid_write;
    logic [255:0] e_rd, rd, v; logic e_err, er, bo; int ac, an, aa;
    $display("[TB] test_reset_mid_write");
    v = {8{$urandom}};
    model_expect(0, 1'b1, 32'h80, v, e_rd, e_err);
    run_access(0, 1'b1, 32'h80, v, 0, ac, an, aa, rd, er, bo);
    // Reset while BUSY.
    sel = 1'b0; we = 1'b1; addr = 32'h80; wdata = '1; req = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL t4_busy_before: got %b expected 1", busy_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("[TB] FAIL t4_abort: got ack=%b busy=%b expected 0 0", ack_a, busy_a); end
    rst = 1'b0; req = 1'b0; model_cnt[0] = 0; model_cnt[1] = 0;
    an = 0;
    repeat (3) begin @(posedge clk); #1; if (ack_a) an++; end
    checks++; if (an !== 0) begin errors++; $display("[TB] FAIL t4_no_ack: got %0d acks expected 0", an); end
    // Reset coinciding with the ACK-entry edge.
    we = 1'b1; addr = 32'h80; wdata = ~v; req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("[TB] FAIL t4_abort_at_ack: got ack=%b busy=%b expected 0 0", ack_a, busy_a); end
    rst = 1'b0; req = 1'b0;
    model_expect(0, 1'b0, 32'h80, '0, e_rd, e_err);
    run_access(0, 1'b0, 32'h80, '0, 0, ac, an, aa, rd, er, bo);
    checks++; if (rd !== v || er !== 1'b0) begin errors++; $display("[TB] FAIL t4_line_intact: got %h expected %h", rd, v); end
    checks++; if (cnt_a !== 16'd1) begin errors++; $display("[TB] FAIL t4_count: got %0d expected 1", cnt_a); end
    // Reset raised during the ACK cycle must mask the ack at once.
    sel = 1'b0; we = 1'b0; addr = 32'h80; req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (ack_a !== 1'b1) begin errors++; $display("[TB] FAIL t4_ack_present: got %b expected 1", ack_a); end
    rst = 1'b1;
    #1;
    checks++; if (ack_a !== 1'b0) begin errors++; $display("[TB] FAIL t4_ack_masked: got %b expected 0", ack_a); end
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; model_cnt[0] = 0; model_cnt[1] = 0;
    checks++; if (cnt_a !== 16'd0 || busy_a !== 1'b0) begin errors++; $display("[TB] FAIL t4_after_reset: got cnt=%0d busy=%b expected 0 0", cnt_a, busy_a); end
  endtask

  task automatic test_counter_wrap;
    logic [255:0] e_rd, rd, d; logic e_err, er, bo; int ac, an, aa;
    $display("[TB] test_counter_wrap");
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      d = {8{$urandom}};
      model_expect(1, 1'b1, 32'(i * 32), d, e_rd, e_err);
      run_access(1, 1'b1, 32'(i * 32), d, 0, ac, an, aa, rd, er, bo);
      checks++; if (cnt !== 16'(i % 16)) begin errors++; $display("[TB] FAIL t5_count_%0d: got %0d expected %0d", i, cnt, i % 16); end
    end
  endtask

  initial begin
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    test_reset();
    test_read_after_write();
    test_errors();
    test_held_req();
    test_lat1();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
